// File: rtl/xs3_pkg.sv
// Shared constants and FSM state type for the Excess-3 to BCD deserialiser.
package xs3_pkg;

    localparam logic [3:0] XS3_OFFSET  = 4'd3;
    localparam logic [3:0] XS3_MIN     = 4'h3;
    localparam logic [3:0] XS3_MAX     = 4'hC;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic {
        COLLECT,
        OUTPUT
    } state_e;

endpackage

// File: rtl/xs3_digit_dec.sv
// Combinational single-digit Excess-3 to BCD decoder with illegal-code flag.
module xs3_digit_dec
    import xs3_pkg::*;
(
    input  logic [3:0] xs3,
    output logic [3:0] bcd,
    output logic       err
);

    always_comb begin
        err = (xs3 < XS3_MIN) || (xs3 > XS3_MAX);
        bcd = err ? BCD_INVALID : (xs3 - XS3_OFFSET);
    end

endmodule

// File: rtl/xs3_to_bcd_deser.sv
// Collects DIGITS Excess-3 digits (first digit most significant) into one
// packed BCD word with a per-digit illegal-code mask, on valid/ready ports.
module xs3_to_bcd_deser
    import xs3_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            in_xs3,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [DIGITS-1:0]     out_err_mask,
    output logic                  out_err
);

    localparam int unsigned CNT_W = $clog2(DIGITS + 1);
    localparam int unsigned WORD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [DIGITS-1:0]   mask_q, mask_d;

    logic [3:0]          dig_bcd;
    logic                dig_err;
    logic                accept;
    logic [WORD_W-1:0]   shreg_shift;
    logic [DIGITS-1:0]   mask_shift;

    xs3_digit_dec u_dec (
        .xs3 (in_xs3),
        .bcd (dig_bcd),
        .err (dig_err)
    );

    assign shreg_shift = (shreg_q << 4) | WORD_W'(dig_bcd);
    assign mask_shift  = (mask_q << 1) | DIGITS'(dig_err);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        mask_d    = mask_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            COLLECT: in_ready = 1'b1;
            OUTPUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase

        accept = in_valid & in_ready;

        if (abort) begin
            // Abort wins over any same-cycle handshake on either side.
            state_d = COLLECT;
            count_d = '0;
            shreg_d = '0;
            mask_d  = '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (accept) begin
                        shreg_d = shreg_shift;
                        mask_d  = mask_shift;
                        if (count_q == LAST) begin
                            state_d = OUTPUT;
                            count_d = '0;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            // Back-to-back: the new digit opens the next word.
                            shreg_d = shreg_shift;
                            mask_d  = mask_shift;
                            if (DIGITS == 1) begin
                                count_d = '0;
                            end else begin
                                state_d = COLLECT;
                                count_d = CNT_W'(1);
                            end
                        end else begin
                            state_d = COLLECT;
                            count_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = COLLECT;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            count_q <= '0;
            shreg_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            mask_q  <= mask_d;
        end
    end

    assign out_bcd      = shreg_q;
    assign out_err_mask = mask_q;
    assign out_err      = |mask_q;

endmodule
